// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared states and default widths for the serial pattern transmitter
package seq_pkg;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_CNT_W = 4;
    localparam int DEF_GAP_W = 4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SHIFT,
        TX_GAP
    } tx_state_t;

endpackage

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - MSB-first serial pattern source with repeat count and idle gap
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int GAP_W = DEF_GAP_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pat_valid,
    output logic                         pat_ready,
    input  logic [PAT_W-1:0]             pat_data,
    input  logic [$clog2(PAT_W+1)-1:0]   pat_len,
    input  logic [CNT_W-1:0]             rep_cnt,
    input  logic [GAP_W-1:0]             gap_len,
    input  logic                         abort,
    output logic                         s_data,
    output logic                         s_valid,
    output logic                         frame_start,
    output logic                         busy,
    output logic                         done
);

    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int IDX_W = $clog2(PAT_W);

    tx_state_t          state, nxt_state;
    logic [PAT_W-1:0]   pat_q, nxt_pat;
    logic [IDX_W-1:0]   len_m1_q, nxt_len_m1;
    logic [GAP_W-1:0]   gap_q, nxt_gap;
    logic [IDX_W-1:0]   bit_idx, nxt_idx;
    logic [CNT_W-1:0]   rep_left, nxt_rep;
    logic [GAP_W-1:0]   gap_cnt, nxt_gap_cnt;
    logic [IDX_W-1:0]   acc_len_m1;
    logic               done_evt;

    assign pat_ready = (state == TX_IDLE) && !rst;
    assign busy      = (state != TX_IDLE);

    // Zero or oversize length both mean a full-width pattern.
    always_comb begin
        if (pat_len == '0 || pat_len > LEN_W'(PAT_W))
            acc_len_m1 = IDX_W'(PAT_W - 1);
        else
            acc_len_m1 = IDX_W'(pat_len - 1'b1);
    end

    always_comb begin
        nxt_state   = state;
        nxt_pat     = pat_q;
        nxt_len_m1  = len_m1_q;
        nxt_gap     = gap_q;
        nxt_idx     = bit_idx;
        nxt_rep     = rep_left;
        nxt_gap_cnt = gap_cnt;
        done_evt    = 1'b0;
        case (state)
            TX_IDLE: begin
                if (pat_valid) begin
                    nxt_state  = TX_SHIFT;
                    nxt_pat    = pat_data;
                    nxt_len_m1 = acc_len_m1;
                    nxt_gap    = gap_len;
                    nxt_idx    = acc_len_m1;
                    nxt_rep    = rep_cnt;
                end
            end
            TX_SHIFT: begin
                if (abort) begin
                    nxt_state = TX_IDLE;
                end else if (bit_idx != '0) begin
                    nxt_idx = bit_idx - 1'b1;
                end else if (rep_left == '0) begin
                    nxt_state = TX_IDLE;
                    done_evt  = 1'b1;
                end else if (gap_q == '0) begin
                    nxt_rep = rep_left - 1'b1;
                    nxt_idx = len_m1_q;
                end else begin
                    nxt_rep     = rep_left - 1'b1;
                    nxt_gap_cnt = gap_q;
                    nxt_state   = TX_GAP;
                end
            end
            TX_GAP: begin
                if (abort) begin
                    nxt_state = TX_IDLE;
                end else begin
                    if (gap_cnt != '0)
                        nxt_gap_cnt = gap_cnt - 1'b1;
                    if (gap_cnt <= GAP_W'(1)) begin
                        nxt_state = TX_SHIFT;
                        nxt_idx   = len_m1_q;
                    end
                end
            end
            default: nxt_state = TX_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= TX_IDLE;
            pat_q       <= '0;
            len_m1_q    <= '0;
            gap_q       <= '0;
            bit_idx     <= '0;
            rep_left    <= '0;
            gap_cnt     <= '0;
            s_data      <= 1'b0;
            s_valid     <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= nxt_state;
            pat_q       <= nxt_pat;
            len_m1_q    <= nxt_len_m1;
            gap_q       <= nxt_gap;
            bit_idx     <= nxt_idx;
            rep_left    <= nxt_rep;
            gap_cnt     <= nxt_gap_cnt;
            s_valid     <= (nxt_state == TX_SHIFT);
            s_data      <= (nxt_state == TX_SHIFT) && nxt_pat[nxt_idx];
            frame_start <= (nxt_state == TX_SHIFT) && (nxt_idx == nxt_len_m1);
            done        <= done_evt;
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - randomized check of seq_pattern_tx against a per-cycle stream model
module tb_seq_pattern_tx;

    localparam int PAT_W = 8;
    localparam int CNT_W = 4;
    localparam int GAP_W = 4;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             pat_valid;
    logic             pat_ready;
    logic [PAT_W-1:0] pat_data;
    logic [LEN_W-1:0] pat_len;
    logic [CNT_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap_len;
    logic             abort;
    logic             s_data;
    logic             s_valid;
    logic             frame_start;
    logic             busy;
    logic             done;

    typedef struct packed {
        logic v;
        logic d;
        logic fs;
        logic dn;
        logic bz;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .pat_valid   (pat_valid),
        .pat_ready   (pat_ready),
        .pat_data    (pat_data),
        .pat_len     (pat_len),
        .rep_cnt     (rep_cnt),
        .gap_len     (gap_len),
        .abort       (abort),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int eff_len(input int len);
        return (len == 0 || len > PAT_W) ? PAT_W : len;
    endfunction

    // Whole transfer as the list of cycles it should produce, ending with the done cycle.
    task automatic push_stream(input logic [PAT_W-1:0] pat, input int len, input int rep, input int gap);
        int   l;
        exp_t e;
        l = eff_len(len);
        for (int r = 0; r <= rep; r++) begin
            for (int i = l - 1; i >= 0; i--) begin
                e.v = 1'b1; e.d = pat[i]; e.fs = (i == l - 1); e.dn = 1'b0; e.bz = 1'b1;
                exp_q.push_back(e);
            end
            if (r < rep) begin
                for (int g = 0; g < gap; g++) begin
                    e = '0; e.bz = 1'b1;
                    exp_q.push_back(e);
                end
            end
        end
        e = '0; e.dn = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        if (abort && exp_q.size() != 0)
            exp_q.delete();
        else if (pat_valid && exp_q.size() == 0)
            push_stream(pat_data, int'(pat_len), int'(rep_cnt), int'(gap_len));
        @(posedge clk);
        @(negedge clk);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : exp_t'(0);
        check("s_valid", 32'(s_valid), 32'(e.v));
        check("s_data", 32'(s_data), 32'(e.d));
        check("frame_start", 32'(frame_start), 32'(e.fs));
        check("done", 32'(done), 32'(e.dn));
        check("busy", 32'(busy), 32'(e.bz));
        check("pat_ready", 32'(pat_ready), 32'(!e.bz));
    endtask

    task automatic xfer(input logic [PAT_W-1:0] pat, input int len, input int rep, input int gap,
                        input int abort_at, input bit chain, input bit abort_first);
        pat_valid = 1'b1;
        pat_data  = pat;
        pat_len   = LEN_W'(len);
        rep_cnt   = CNT_W'(rep);
        gap_len   = GAP_W'(gap);
        abort     = abort_first;
        tick();
        pat_valid = 1'b0;
        abort     = 1'b0;
        pat_data  = PAT_W'($urandom);
        pat_len   = LEN_W'($urandom);
        rep_cnt   = CNT_W'($urandom);
        gap_len   = GAP_W'($urandom);
        for (int c = 1; exp_q.size() != 0 && c < 400; c++) begin
            abort = (c == abort_at);
            tick();
        end
        abort = 1'b0;
        check("drained", 32'(exp_q.size()), 32'd0);
        if (!chain)
            tick();
    endtask

    initial begin
        rst       = 1'b1;
        pat_valid = 1'b0;
        pat_data  = '0;
        pat_len   = '0;
        rep_cnt   = '0;
        gap_len   = '0;
        abort     = 1'b0;
        #1;
        check("rst_pat_ready", 32'(pat_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s_valid", 32'(s_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_pat_ready", 32'(pat_ready), 32'd1);
        @(negedge clk);
        tick();

        xfer(8'b101, 3, 0, 0, -1, 1'b0, 1'b0);
        xfer(8'b10, 2, 2, 3, -1, 1'b0, 1'b0);
        xfer(8'b101, 3, 1, 0, -1, 1'b1, 1'b0);
        xfer(8'b0110, 4, 0, 0, -1, 1'b0, 1'b0);
        xfer(8'h81, 0, 0, 0, -1, 1'b0, 1'b0);
        xfer(8'h81, PAT_W + 3, 0, 0, -1, 1'b0, 1'b0);
        xfer(8'h01, 1, 0, 0, -1, 1'b0, 1'b0);
        xfer(8'hFF, 8, 3, 0, 4, 1'b0, 1'b0);
        xfer(8'hC3, 5, 1, 2, -1, 1'b0, 1'b1);
        xfer(8'h5A, 4, 2, 3, 6, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a shift.
        pat_valid = 1'b1; pat_data = 8'hA5; pat_len = 4'd8; rep_cnt = '0; gap_len = '0;
        tick();
        pat_valid = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_s_valid", 32'(s_valid), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_pat_ready", 32'(pat_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst_pat_ready", 32'(pat_ready), 32'd1);
        @(negedge clk);
        repeat (3) tick();

        for (int n = 0; n < 40; n++) begin
            int idle;
            idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) begin
                abort = ($urandom_range(0, 3) == 0);
                tick();
                abort = 1'b0;
            end
            xfer(PAT_W'($urandom), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 4) == 0) ? $urandom_range(1, 12) : -1,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter: the source side of the serial bit-stream interface that the team's sequence detectors consume.
- Accepts a pattern word over a valid/ready handshake and shifts it out MSB-first on s_data, one bit per clk.
- Optionally repeats the pattern N extra times, with a programmable idle gap between repetitions.
- Used as a stimulus/traffic source in front of the detector blocks, e.g. emitting "101" frames.

Parameters:
- PAT_W, 8, maximum pattern length in bits.
- CNT_W, 4, width of the repeat-count field.
- GAP_W, 4, width of the inter-repetition gap field.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- pat_valid  in  1  pattern request valid.
- pat_ready  out  1  block can accept a pattern.
- pat_data  in  PAT_W  pattern bits; bits [len-1:0] are used.
- pat_len  in  $clog2(PAT_W+1)  number of bits to send.
- rep_cnt  in  CNT_W  extra repetitions; the pattern is sent rep_cnt+1 times.
- gap_len  in  GAP_W  idle cycles between repetitions.
- abort  in  1  cancel the transfer in progress.
- s_data  out  1  serial data bit.
- s_valid  out  1  s_data carries a pattern bit this cycle.
- frame_start  out  1  high with the first bit of each repetition.
- busy  out  1  transfer in progress (state != IDLE).
- done  out  1  one-cycle pulse after the final bit of the final repetition.

Behaviour:
- Reset:
  - rst is asynchronous and active-high. While rst=1, state=IDLE and all outputs (including pat_ready) are forced to 0 immediately.
  - pat_ready goes to 1 in the first cycle after rst deasserts.
- Registered outputs: s_data, s_valid, frame_start and done are registered. pat_ready = (state==IDLE) && !rst. busy = (state!=IDLE).
- Accept:
  - A transfer occurs on a clk edge with pat_valid && pat_ready.
  - On accept, latch pat_data, the effective length L, rep_cnt and gap_len. Input changes after accept have no effect.
- Effective length L:
  - pat_len==0 means L=PAT_W.
  - pat_len>PAT_W is clamped to PAT_W.
- State machine (states defined in the shared package):
  - IDLE: on accept, go to SHIFT with bit_idx=L-1 and rep_left=rep_cnt.
  - SHIFT:
    - Each cycle drives s_valid=1 and s_data=pat[bit_idx], then decrements bit_idx.
    - frame_start=1 when bit_idx==L-1.
    - After bit 0:
      - if rep_left==0, go to IDLE and pulse done;
      - else if gap==0, decrement rep_left and reload bit_idx=L-1, staying in SHIFT (back-to-back repetitions, no bubble);
      - else decrement rep_left, load gap_cnt=gap, and go to GAP.
  - GAP:
    - s_valid=0, s_data=0 for exactly gap cycles.
    - Then go to SHIFT with bit_idx=L-1.
- Latency:
  - Accept at edge k: bits appear in cycles k+1 .. k+L.
  - done=1 in cycle k+L+1, which is also the first IDLE cycle, so pat_ready=1 there.
  - A new accept at that same edge is legal and produces a continuous stream: the next first bit follows the done cycle.
- Total busy cycles per transfer: (rep_cnt+1)*L + rep_cnt*gap.
- Outside SHIFT, s_data=0 and s_valid=0.
- Abort:
  - In SHIFT or GAP, go to IDLE at the next edge. s_valid drops that cycle. No done pulse.
  - Abort is ignored in IDLE. abort and pat_valid together in IDLE: the accept proceeds.
- Reset mid-transfer: asynchronous return to IDLE. No done pulse. The latched pattern is discarded.
- Counter widths:
  - bit_idx: $clog2(PAT_W) bits.
  - rep_left: CNT_W bits.
  - gap_cnt: GAP_W bits.
  - No counter wraps: each is only decremented while nonzero.

Decomposition:
- Package seq_pkg:
  - tx_state_t enum {TX_IDLE, TX_SHIFT, TX_GAP}.
  - Localparams for default widths.
- No sub-module. The shift index, repeat counter and gap counter live in one always_ff beside a single always_comb next-state block.

Test Plan:
- Reset: rst=1 mid-SHIFT of pattern 8'hA5 → s_valid, done and pat_ready are 0 the same cycle; after release pat_ready=1 and no further bits.
- Basic: pat_data=3'b101, pat_len=3, rep_cnt=0 → s_data 1,0,1 with s_valid=1 for 3 cycles, frame_start on the first bit, done one cycle later. A seq detector fed from s_data must flag once.
- Repeat with gap: pat=2'b10, L=2, rep_cnt=2, gap_len=3 → 1,0,idle×3,1,0,idle×3,1,0, then done. busy for 12 cycles. frame_start 3 times.
- Back-to-back: pat=3'b101, rep_cnt=1, gap_len=0 → 1,0,1,1,0,1 with no bubble. A second pattern 4'b0110 presented on the done cycle is accepted and starts the following cycle.
- Length boundaries: pat_len=0 and pat_len=PAT_W+3 with pat_data=8'h81 → 8 bits 1,0,0,0,0,0,0,1 in both cases. pat_len=1 with pat_data[0]=1 → a single bit 1.
- Abort: pat=8'hFF, rep_cnt=3, abort asserted in the 4th bit cycle → s_valid=0 from the next cycle, no done, pat_ready=1.
